// File: rtl/mmio_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mmio_bus_arbiter_if
//
// Purpose:
//   Bundles every request, response and shared-bus signal of the MMIO bus
//   arbiter. The arbiter connects through the slave modport: it serves the two
//   requesters and drives the shared peripheral bus. The master modport is the
//   opposite view (requesters plus peripheral decode) for whatever sits around
//   the arbiter.
//
// Signal summary:
//   core_req/addr/wdata/wmask/rstrb   core access request (held until core_ack)
//   core_ack, core_rdata              one-cycle completion pulse and read data
//   pim_req/addr/wdata/wmask/rstrb    PIM engine access request
//   pim_ack, pim_rdata                one-cycle completion pulse and read data
//   bus_addr/wdata/wmask/rstrb        shared peripheral bus (strobes one cycle)
//   bus_rdata                         shared peripheral bus read data
//   busy                              arbiter is not idle
//   grant_owner                       0 = core, 1 = PIM (current/most recent)
// -----------------------------------------------------------------------------
interface mmio_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // core requester
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [MASK_W-1:0] core_wmask;
    logic              core_rstrb;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;

    // PIM requester
    logic              pim_req;
    logic [ADDR_W-1:0] pim_addr;
    logic [DATA_W-1:0] pim_wdata;
    logic [MASK_W-1:0] pim_wmask;
    logic              pim_rstrb;
    logic              pim_ack;
    logic [DATA_W-1:0] pim_rdata;

    // shared peripheral bus
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [MASK_W-1:0] bus_wmask;
    logic              bus_rstrb;
    logic [DATA_W-1:0] bus_rdata;

    // status
    logic              busy;
    logic              grant_owner;

    // arbiter side
    modport slave (
        input  core_req, core_addr, core_wdata, core_wmask, core_rstrb,
        input  pim_req, pim_addr, pim_wdata, pim_wmask, pim_rstrb,
        input  bus_rdata,
        output core_ack, core_rdata, pim_ack, pim_rdata,
        output bus_addr, bus_wdata, bus_wmask, bus_rstrb,
        output busy, grant_owner
    );

    // requester / peripheral side
    modport master (
        output core_req, core_addr, core_wdata, core_wmask, core_rstrb,
        output pim_req, pim_addr, pim_wdata, pim_wmask, pim_rstrb,
        output bus_rdata,
        input  core_ack, core_rdata, pim_ack, pim_rdata,
        input  bus_addr, bus_wdata, bus_wmask, bus_rstrb,
        input  busy, grant_owner
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_bus_arbiter
//
// Purpose:
//   Shares the single memory-mapped peripheral bus between the RISC-V core and
//   the PIM engine. Accesses are serialised with round-robin fairness; each
//   granted access produces exactly one ack and at most one one-cycle strobe
//   (write enables or read strobe) on the shared bus.
//
//   Access timeline (cycle 0 = request seen in IDLE):
//     write / null : IDLE(0) -> ISSUE(1) -> ACK(2)
//     read         : IDLE(0) -> ISSUE(1) -> WAIT x RD_LATENCY -> ACK(2+RD_LATENCY)
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset; aborts any access silently
//   bus_if    mmio_bus_arbiter_if.slave (requests, acks, read data, shared bus,
//             busy, grant_owner)
//
// Parameters:
//   ADDR_W      address width
//   DATA_W      data width (byte mask is DATA_W/8)
//   RD_LATENCY  cycles from the read strobe cycle to valid bus_rdata (0..7)
// -----------------------------------------------------------------------------
module mmio_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    mmio_bus_arbiter_if.slave bus_if
);
    localparam int         MASK_W    = DATA_W / 8;
    localparam logic [2:0] RD_LAT_C  = 3'(RD_LATENCY);
    localparam logic       RD_ZERO_C = (RD_LATENCY == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    // request selection (combinational view of IDLE arbitration)
    logic              sel_pim_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [MASK_W-1:0] sel_wmask_s;
    logic              sel_rstrb_s;

    // read data value handed to the owner when entering ACK
    logic [DATA_W-1:0] cap_data_s;

    // registered outputs and bookkeeping
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [MASK_W-1:0] bus_wmask_r;
    logic              bus_rstrb_r;
    logic              core_ack_r;
    logic              pim_ack_r;
    logic [DATA_W-1:0] core_rdata_r;
    logic [DATA_W-1:0] pim_rdata_r;
    logic              busy_r;
    logic              grant_owner_r;
    logic              last_owner_r;
    logic [2:0]        cnt_r;

    // State register of the access FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. In ISSUE, bus_rstrb_r is high exactly when the latched
    // access is a genuine read (rstrb set and no write enables), so it doubles
    // as the read/write decision for the rest of the access.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus_if.core_req || bus_if.pim_req) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus_rstrb_r && !RD_ZERO_C) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Round-robin selection: a lone requester wins; on a tie the requester
    // that did not own the previous grant wins.
    always_comb begin
        sel_pim_s = 1'b0;
        if (bus_if.core_req && bus_if.pim_req) begin
            sel_pim_s = ~last_owner_r;
        end else if (bus_if.pim_req) begin
            sel_pim_s = 1'b1;
        end else begin
            sel_pim_s = 1'b0;
        end
    end

    // Multiplex the selected requester's access fields.
    always_comb begin
        sel_addr_s  = bus_if.core_addr;
        sel_wdata_s = bus_if.core_wdata;
        sel_wmask_s = bus_if.core_wmask;
        sel_rstrb_s = bus_if.core_rstrb;
        if (sel_pim_s) begin
            sel_addr_s  = bus_if.pim_addr;
            sel_wdata_s = bus_if.pim_wdata;
            sel_wmask_s = bus_if.pim_wmask;
            sel_rstrb_s = bus_if.pim_rstrb;
        end else begin
            sel_addr_s  = bus_if.core_addr;
            sel_wdata_s = bus_if.core_wdata;
            sel_wmask_s = bus_if.core_wmask;
            sel_rstrb_s = bus_if.core_rstrb;
        end
    end

    // Value returned with the ack: bus_rdata for reads (ISSUE when the latency
    // is zero, last WAIT cycle otherwise), zero for writes and null accesses.
    always_comb begin
        cap_data_s = '0;
        if (state_r == ST_ISSUE) begin
            if (bus_rstrb_r) begin
                cap_data_s = bus_if.bus_rdata;
            end else begin
                cap_data_s = '0;
            end
        end else if (state_r == ST_WAIT) begin
            cap_data_s = bus_if.bus_rdata;
        end else begin
            cap_data_s = '0;
        end
    end

    // Shared-bus registers: latched on the grant, strobes live only in ISSUE,
    // address and write data hold their last value afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_addr_r    <= '0;
            bus_wdata_r   <= '0;
            bus_wmask_r   <= '0;
            bus_rstrb_r   <= 1'b0;
            grant_owner_r <= 1'b1;
        end else begin
            bus_wmask_r <= '0;
            bus_rstrb_r <= 1'b0;
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_ISSUE)) begin
                grant_owner_r <= sel_pim_s;
                bus_addr_r    <= sel_addr_s;
                bus_wdata_r   <= sel_wdata_s;
                bus_wmask_r   <= sel_wmask_s;
                // a write always wins over a simultaneous read request
                bus_rstrb_r   <= sel_rstrb_s && (sel_wmask_s == '0);
            end
        end
    end

    // Read-latency counter: loaded leaving ISSUE, counts down through WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 3'd0;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (state_nxt_s == ST_WAIT) begin
                        cnt_r <= RD_LAT_C;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Response registers: one-cycle ack plus read data to the grant owner;
    // the other requester's read data holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ack_r   <= 1'b0;
            pim_ack_r    <= 1'b0;
            core_rdata_r <= '0;
            pim_rdata_r  <= '0;
        end else begin
            core_ack_r <= 1'b0;
            pim_ack_r  <= 1'b0;
            if (state_nxt_s == ST_ACK) begin
                if (grant_owner_r) begin
                    pim_ack_r   <= 1'b1;
                    pim_rdata_r <= cap_data_s;
                end else begin
                    core_ack_r   <= 1'b1;
                    core_rdata_r <= cap_data_s;
                end
            end
        end
    end

    // Fairness history and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_ACK) begin
                last_owner_r <= grant_owner_r;
            end
        end
    end

    assign bus_if.bus_addr    = bus_addr_r;
    assign bus_if.bus_wdata   = bus_wdata_r;
    assign bus_if.bus_wmask   = bus_wmask_r;
    assign bus_if.bus_rstrb   = bus_rstrb_r;
    assign bus_if.core_ack    = core_ack_r;
    assign bus_if.pim_ack     = pim_ack_r;
    assign bus_if.core_rdata  = core_rdata_r;
    assign bus_if.pim_rdata   = pim_rdata_r;
    assign bus_if.busy        = busy_r;
    assign bus_if.grant_owner = grant_owner_r;

    mmio_bus_arbiter_chk #(
        .MASK_W (MASK_W)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus_wmask (bus_wmask_r),
        .bus_rstrb (bus_rstrb_r),
        .core_ack  (core_ack_r),
        .pim_ack   (pim_ack_r)
    );
endmodule

// -----------------------------------------------------------------------------
// mmio_bus_arbiter_chk
//
// Purpose:
//   Protocol properties of the arbiter outputs: never a strobe in an ack
//   cycle, never two acks at once, never a read strobe together with write
//   enables.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   bus_wmask, bus_rstrb shared-bus strobes
//   core_ack, pim_ack    completion pulses
// -----------------------------------------------------------------------------
module mmio_bus_arbiter_chk #(
    parameter int MASK_W = 4
) (
    input logic              clk,
    input logic              reset_n,
    input logic [MASK_W-1:0] bus_wmask,
    input logic              bus_rstrb,
    input logic              core_ack,
    input logic              pim_ack
);
    a_no_strobe_in_ack: assert property (@(posedge clk) disable iff (!reset_n)
        !(((|bus_wmask) || bus_rstrb) && (core_ack || pim_ack)));

    a_single_ack: assert property (@(posedge clk) disable iff (!reset_n)
        !(core_ack && pim_ack));

    a_exclusive_strobe: assert property (@(posedge clk) disable iff (!reset_n)
        !((|bus_wmask) && bus_rstrb));
endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single memory-mapped peripheral bus (GPIO at 0x0000_0FFC, other MMIO) between two requesters: the RISC-V core and the PIM engine.
- Sits between the requesters and the peripheral decode logic.
- Serialises accesses with round-robin fairness and issues exactly one one-cycle bus strobe per granted access.
- Returns a one-cycle ack, plus read data for reads, to the granted requester.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; mask width is DATA_W/8
RD_LATENCY, 1, cycles from the read strobe cycle to valid bus_rdata (legal range 0..7)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
core_req  in  1  core access request; held until core_ack
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_wmask  in  DATA_W/8  core byte write enables
core_rstrb  in  1  core read request
core_ack  out  1  one-cycle completion pulse to core
core_rdata  out  DATA_W  read data, valid while core_ack=1
pim_req, pim_addr, pim_wdata, pim_wmask, pim_rstrb  in  as core_*  PIM request
pim_ack  out  1  one-cycle completion pulse to PIM
pim_rdata  out  DATA_W  read data, valid while pim_ack=1
bus_addr  out  ADDR_W  shared bus address
bus_wdata  out  DATA_W  shared bus write data
bus_wmask  out  DATA_W/8  shared bus byte enables
bus_rstrb  out  1  shared bus read strobe
bus_rdata  in  DATA_W  shared bus read data
busy  out  1  high in every state except IDLE
grant_owner  out  1  0=core, 1=PIM; the owner of the current or most recent grant

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - All acks, bus_wmask, bus_rstrb and busy go to 0.
  - bus_addr, bus_wdata, core_rdata and pim_rdata go to 0.
  - last_owner=1, so the core wins the first tie. grant_owner=1.
  - Reset mid-access aborts the access silently: no ack and no further strobe.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Selection when req is high:
    - Only one req high: that requester is selected.
    - Both high: the requester other than last_owner is selected.
  - Latch the selected addr, wdata, wmask and rstrb into registers; set grant_owner; go to ISSUE.
  - No req high: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - bus_addr and bus_wdata are driven from the latch.
  - bus_wmask is driven from the latched mask.
  - bus_rstrb = latched rstrb AND (latched wmask == 0).
  - Write (wmask != 0): go to ACK. If rstrb was also set, the write wins, no read strobe is issued, and rdata returns 0.
  - Read, RD_LATENCY=0: capture bus_rdata in this cycle; go to ACK.
  - Read, RD_LATENCY>0: load the counter with RD_LATENCY; go to WAIT.
  - Null access (wmask=0, rstrb=0): no strobe; go to ACK with rdata=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture bus_rdata and go to ACK. WAIT therefore lasts RD_LATENCY cycles.
- ACK (1 cycle):
  - Assert the owner's ack.
  - The owner's rdata equals the captured value; the other requester's rdata holds its previous value.
  - last_owner <= grant_owner; go to IDLE.
- Strobe rules:
  - bus_wmask=0 and bus_rstrb=0 in every state other than ISSUE, so no peripheral write can occur outside ISSUE.
  - bus_addr and bus_wdata hold their last values outside ISSUE.
- Request rules:
  - Requester inputs are sampled only in IDLE; changes while not granted are ignored.
  - A req still high in the cycle after ack is treated as a new request.
  - Back-to-back requests from both requesters alternate strictly.
- Latency from req seen in IDLE (cycle 0) to ack:
  - Writes: ack at cycle 2.
  - Reads: ack at cycle 2+RD_LATENCY.
  - Peak throughput: one access per 3 cycles.
- Every granted access produces exactly one ack, and at most one strobe cycle.

Test Plan:
- Core write 0xA5A5_1234, wmask=0xF, addr=0x0FFC -> bus_wmask=0xF for exactly one cycle (cycle 1); core_ack at cycle 2; pim_ack stays 0; grant_owner=0.
- PIM read with RD_LATENCY=1, bus_rdata=0xDEAD_BEEF at cycle 2 -> bus_rstrb high at cycle 1 only; pim_ack at cycle 3 with pim_rdata=0xDEAD_BEEF.
- Both req high out of reset and held for 4 accesses -> grant order core, PIM, core, PIM; no cycle ever has a strobe while ack=1.
- Core request with wmask=0x3 and rstrb=1 -> bus_wmask=0x3, bus_rstrb stays 0; core_ack with core_rdata=0. A null request (wmask=0, rstrb=0) -> ack at cycle 2 with no strobe.
- reset_n pulsed low during WAIT of a PIM read -> no pim_ack; all outputs at reset values; first post-reset tie is granted to the core.
- RD_LATENCY=0 and RD_LATENCY=7 builds -> read ack at cycle 2 and cycle 9 respectively, with rdata matching bus_rdata on the capture cycle.
